// File: rtl/burst_mem_responder_pkg.sv
// Shared types and constants for the burst memory responder.
// Optional feature macro: MEM_OOR_ERR_EN (out-of-range request detection).
package burst_mem_responder_pkg;

  // Byte address that maps to array word 0, and the default array size in bytes.
  localparam logic [31:0] MEM_BASE_ADDR = 32'h8002_0000;
  localparam int          MEM_DEPTH     = 2048;

  // Burst length encoding carried on access_size.
  typedef enum logic [1:0] {
    ACC_1  = 2'd0,
    ACC_4  = 2'd1,
    ACC_8  = 2'd2,
    ACC_16 = 2'd3
  } access_size_e;

  // Store width encoding carried on store_size; encoding 3 behaves as a word.
  typedef enum logic [1:0] {
    ST_WORD = 2'd0,
    ST_HALF = 2'd1,
    ST_BYTE = 2'd2
  } store_size_e;

  // Responder FSM states, also exported for observation.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RD_BURST = 2'd1,
    S_WR_BURST = 2'd2
  } state_e;

  // Number of words moved by a request of the given access size.
  function automatic logic [4:0] burst_len(access_size_e acc);
    logic [4:0] len;
    case (acc)
      ACC_4:   len = 5'd4;
      ACC_8:   len = 5'd8;
      ACC_16:  len = 5'd16;
      default: len = 5'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/burst_mem_responder_if.sv
// Request/response bundle between a pipeline stage (master) and the
// burst memory responder (slave).
// Optional feature macro: MEM_OOR_ERR_EN adds the addr_err signal.
//
// Handshake: enable is the request-valid. A request is taken on a rising
// clock edge where enable=1, stall=0 and the responder is not busy; the
// requester must hold address/access_size/read_not_write/enable stable
// until that edge. While busy=1 the request fields are ignored and only
// stall (freeze) and data_in (one word per non-stalled write beat) matter.
interface burst_mem_responder_if;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [1:0]  access_size;
  logic [1:0]  store_size;
  logic        read_not_write;
  logic        enable;
  logic        stall;
  logic        busy;
`ifdef MEM_OOR_ERR_EN
  logic        addr_err;
`endif
  burst_mem_responder_pkg::state_e fsm_state;

  modport slave (
    input  address, data_in, access_size, store_size, read_not_write, enable, stall,
`ifdef MEM_OOR_ERR_EN
    output addr_err,
`endif
    output data_out, busy, fsm_state
  );

  modport master (
    output address, data_in, access_size, store_size, read_not_write, enable, stall,
`ifdef MEM_OOR_ERR_EN
    input  addr_err,
`endif
    input  data_out, busy, fsm_state
  );
endinterface

// File: rtl/burst_mem_responder_mem_word_array.sv
// Word-organised single-port RAM with per-byte write enables and a
// registered, resettable read-data output. Array contents are never reset.
module mem_word_array #(
  parameter int WORDS = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_en,
  input  logic [3:0]    wr_be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  // Byte-lane writes; wr_be[3] is lane [31:24].
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) begin
        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read register: updates only on a read beat, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/burst_mem_responder.sv
// Responder end of the pipeline memory interface: single and burst
// (1/4/8/16-word) reads and writes, word/halfword/byte single stores with
// big-endian lanes, busy during bursts, stall freezes all progress.
// Optional feature macro: MEM_OOR_ERR_EN rejects requests whose offset from
// BASE_ADDR is >= DEPTH and pulses addr_err; otherwise addresses wrap.
module burst_mem_responder
  import burst_mem_responder_pkg::*;
#(
  parameter int          DEPTH     = MEM_DEPTH,
  parameter logic [31:0] BASE_ADDR = MEM_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   rst,
  burst_mem_responder_if.slave   bus
);

  localparam int OFFW  = $clog2(DEPTH);
  localparam int AW    = OFFW - 2;
  localparam int WORDS = DEPTH / 4;

  state_e        state;
  logic          busy_q;
  logic [3:0]    beat_cnt;
  logic [3:0]    last_beat;
  logic [AW-1:0] base_idx;

  logic [31:0]   req_off;
  logic [AW-1:0] req_idx;
  logic [4:0]    req_len;
  logic          oor;
  logic          accept;

  logic [3:0]    st_be;
  logic [31:0]   st_data;

  logic [AW-1:0] mem_idx;
  logic          rd_en;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;
  logic [31:0]   rdata;

  // Request decode: offset, word index, length, range check, acceptance.
  always_comb begin
    req_off = bus.address - BASE_ADDR;
    req_idx = req_off[OFFW-1:2];
    req_len = burst_len(access_size_e'(bus.access_size));
`ifdef MEM_OOR_ERR_EN
    oor     = (req_off >= 32'(DEPTH));
`else
    oor     = 1'b0;
`endif
    accept  = (state == S_IDLE) && bus.enable && !bus.stall && !oor;
  end

  // Offset bits that never select a word: byte lanes come from address,
  // and without range checking the high bits simply wrap away.
  logic unused_off_bits;
`ifdef MEM_OOR_ERR_EN
  assign unused_off_bits = ^req_off[1:0];
`else
  assign unused_off_bits = ^{req_off[31:OFFW], req_off[1:0]};
`endif

  // Single-store lane decode (big-endian): data replicated across lanes,
  // byte enables select which lanes actually change.
  always_comb begin
    st_be   = 4'hF;
    st_data = bus.data_in;
    case (store_size_e'(bus.store_size))
      ST_HALF: begin
        st_be   = bus.address[1] ? 4'b0011 : 4'b1100;
        st_data = {2{bus.data_in[15:0]}};
      end
      ST_BYTE: begin
        st_be   = 4'b1000 >> bus.address[1:0];
        st_data = {4{bus.data_in[7:0]}};
      end
      default: ;
    endcase
  end

  // Array control: beat 0 goes out in the accept cycle, later beats use the
  // latched base index plus the beat number (wrapping in the AW-bit add).
  always_comb begin
    mem_idx = base_idx + AW'(beat_cnt);
    rd_en   = 1'b0;
    wr_be   = 4'h0;
    wr_data = bus.data_in;
    if (accept) begin
      mem_idx = req_idx;
      if (bus.read_not_write) begin
        rd_en = 1'b1;
      end else if (req_len == 5'd1) begin
        wr_be   = st_be;
        wr_data = st_data;
      end else begin
        wr_be = 4'hF;
      end
    end else if (!bus.stall) begin
      if (state == S_RD_BURST) rd_en = 1'b1;
      if (state == S_WR_BURST) wr_be = 4'hF;
    end
  end

`ifdef MEM_OOR_ERR_EN
  logic err_q;
`endif

  // Burst FSM with beat counter, latched burst parameters and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy_q    <= 1'b0;
      beat_cnt  <= '0;
      last_beat <= '0;
      base_idx  <= '0;
`ifdef MEM_OOR_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
`ifdef MEM_OOR_ERR_EN
      err_q <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (accept) begin
            base_idx  <= req_idx;
            last_beat <= 4'(req_len - 5'd1);
            if (req_len != 5'd1) begin
              beat_cnt <= 4'd1;
              busy_q   <= 1'b1;
              state    <= bus.read_not_write ? S_RD_BURST : S_WR_BURST;
            end
          end
`ifdef MEM_OOR_ERR_EN
          else if (bus.enable && !bus.stall && oor) begin
            err_q <= 1'b1;
          end
`endif
        end
        S_RD_BURST, S_WR_BURST: begin
          if (!bus.stall) begin
            if (beat_cnt == last_beat) begin
              beat_cnt <= '0;
              busy_q   <= 1'b0;
              state    <= S_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
            end
          end
        end
        default: begin
          beat_cnt <= '0;
          busy_q   <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  mem_word_array #(
    .WORDS (WORDS),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .rd_en (rd_en),
    .wr_be (wr_be),
    .idx   (mem_idx),
    .wdata (wr_data),
    .rdata (rdata)
  );

  assign bus.data_out  = rdata;
  assign bus.busy      = busy_q;
  assign bus.fsm_state = state;
`ifdef MEM_OOR_ERR_EN
  assign bus.addr_err  = err_q;
`endif

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder: single/sub-word stores, stalled
// write burst, read bursts with wrap, reset mid-burst, requests while busy.
// Optional feature macro: MEM_OOR_ERR_EN (out-of-range rejection checks).
module tb_burst_mem_responder;
  import burst_mem_responder_pkg::*;

  localparam logic [31:0] B = 32'h8002_0000;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  burst_mem_responder_if bus();

  burst_mem_responder #(.DEPTH(2048), .BASE_ADDR(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 ns after the edge; inputs changed there are
  // taken at the following edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus;
    bus.enable         = 1'b0;
    bus.stall          = 1'b0;
    bus.read_not_write = 1'b1;
    bus.address        = B;
    bus.data_in        = '0;
    bus.access_size    = 2'd0;
    bus.store_size     = 2'd0;
  endtask

  task automatic set_req(input logic rnw, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] acc, input logic [1:0] st);
    bus.enable         = 1'b1;
    bus.read_not_write = rnw;
    bus.address        = addr;
    bus.data_in        = data;
    bus.access_size    = acc;
    bus.store_size     = st;
  endtask

  task automatic write_single(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] st);
    set_req(1'b0, addr, data, 2'd0, st);
    tick;
    bus.enable = 1'b0;
  endtask

  task automatic read_single(input logic [31:0] addr);
    set_req(1'b1, addr, '0, 2'd0, 2'd0);
    tick;
    bus.enable = 1'b0;
  endtask

  initial begin
    logic [31:0] wrap_exp [4];
    int busy_cycles;
    wrap_exp[0] = 32'hA000_0000;
    wrap_exp[1] = 32'hA111_1111;
    wrap_exp[2] = 32'hA222_2222;
    wrap_exp[3] = 32'hA333_3333;

    // Reset
    idle_bus;
    rst = 1'b1;
    tick;
    tick;
    check("rst_data_out", bus.data_out, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_state", 32'(bus.fsm_state), 32'(S_IDLE));
    rst = 1'b0;
    tick;

    // Single word write and read-back
    write_single(B + 32'h10, 32'hDEAD_BEEF, 2'd0);
    read_single(B + 32'h10);
    check("word_rd", bus.data_out, 32'hDEAD_BEEF);
    check("word_rd_busy", 32'(bus.busy), 32'h0);

    // Sub-word stores
    write_single(B + 32'h20, 32'h1122_3344, 2'd0);
    write_single(B + 32'h21, 32'h0000_00AA, 2'd2);
    read_single(B + 32'h20);
    check("byte_lane1", bus.data_out, 32'h11AA_3344);
    write_single(B + 32'h22, 32'h0000_BBCC, 2'd1);
    read_single(B + 32'h20);
    check("half_lane1", bus.data_out, 32'h11AA_BBCC);

    // Stall in idle blocks acceptance
    set_req(1'b1, B + 32'h10, '0, 2'd0, 2'd0);
    bus.stall = 1'b1;
    tick;
    check("idle_stall_hold", bus.data_out, 32'h11AA_BBCC);
    check("idle_stall_busy", 32'(bus.busy), 32'h0);
    bus.stall = 1'b0;
    tick;
    bus.enable = 1'b0;
    check("idle_stall_release", bus.data_out, 32'hDEAD_BEEF);

    write_single(B + 32'h23, 32'h0000_0055, 2'd2);
    read_single(B + 32'h20);
    check("byte_lane3", bus.data_out, 32'h11AA_BB55);

    // Guard word just past the write burst
    write_single(B + 32'h50, 32'h5050_5050, 2'd0);

    // 4-word write burst with a stall right after acceptance
    set_req(1'b0, B + 32'h40, 32'd1, 2'd1, 2'd0);
    tick;
    check("wb_busy_accept", 32'(bus.busy), 32'h1);
    check("wb_state", 32'(bus.fsm_state), 32'(S_WR_BURST));
    bus.enable  = 1'b0;
    bus.stall   = 1'b1;
    bus.data_in = 32'h0BAD_0BAD;
    tick;
    check("wb_busy_stall", 32'(bus.busy), 32'h1);
    bus.stall = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      bus.data_in = 32'(k);
      tick;
    end
    check("wb_busy_end", 32'(bus.busy), 32'h0);

    // 4-word read burst of the same words
    set_req(1'b1, B + 32'h40, '0, 2'd1, 2'd0);
    tick;
    bus.enable = 1'b0;
    busy_cycles = 0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rb_beat%0d", k), bus.data_out, 32'(k + 1));
      if (bus.busy) busy_cycles++;
      if (k != 3) tick;
    end
    check("rb_busy_cycles", 32'(busy_cycles), 32'd3);
    tick;
    check("rb_hold", bus.data_out, 32'd4);
    read_single(B + 32'h50);
    check("wb_guard", bus.data_out, 32'h5050_5050);

    // Read burst wrapping across the top of the array
    write_single(B + 32'h7F8, wrap_exp[0], 2'd0);
    write_single(B + 32'h7FC, wrap_exp[1], 2'd0);
    write_single(B + 32'h000, wrap_exp[2], 2'd0);
    write_single(B + 32'h004, wrap_exp[3], 2'd0);
    set_req(1'b1, B + 32'h7F8, '0, 2'd1, 2'd0);
    tick;
    bus.enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wrap_beat%0d", k), bus.data_out, wrap_exp[k]);
      if (k != 3) tick;
    end

`ifdef MEM_OOR_ERR_EN
    // Out-of-range request is rejected
    set_req(1'b1, B + 32'd2048, '0, 2'd0, 2'd0);
    tick;
    bus.enable = 1'b0;
    check("oor_err", 32'(bus.addr_err), 32'h1);
    check("oor_busy", 32'(bus.busy), 32'h0);
    check("oor_hold", bus.data_out, wrap_exp[3]);
    tick;
    check("oor_err_pulse", 32'(bus.addr_err), 32'h0);
`else
    // Without range checking the address wraps to word 0
    read_single(B + 32'd2048);
    check("oor_wrap", bus.data_out, wrap_exp[2]);
`endif

    // Reset at the third beat of a 16-word read burst
    set_req(1'b1, B + 32'h40, '0, 2'd3, 2'd0);
    tick;
    bus.enable = 1'b0;
    check("rst16_beat0", bus.data_out, 32'd1);
    tick;
    check("rst16_beat1", bus.data_out, 32'd2);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rst16_busy", 32'(bus.busy), 32'h0);
    check("rst16_data", bus.data_out, 32'h0);
    check("rst16_state", 32'(bus.fsm_state), 32'(S_IDLE));
    read_single(B + 32'h10);
    check("rst16_readback", bus.data_out, 32'hDEAD_BEEF);

    // Write request while busy is ignored
    set_req(1'b1, B + 32'h20, '0, 2'd1, 2'd0);
    tick;
    check("busy_rd_beat0", bus.data_out, 32'h11AA_BB55);
    set_req(1'b0, B + 32'h10, 32'hFFFF_FFFF, 2'd0, 2'd0);
    tick;
    tick;
    tick;
    bus.enable = 1'b0;
    check("busy_ign_busy", 32'(bus.busy), 32'h0);
    read_single(B + 32'h10);
    check("busy_ign_word", bus.data_out, 32'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
